// File: rtl/mlp_pkg.sv
// Shared types and helpers for the time-multiplexed MLP layer.
package mlp_pkg;

  localparam int RES_DEF  = 8;
  localparam int FRAC_DEF = 4;
  localparam int ONE_DEF  = 1 << FRAC_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Wide enough for N_IN full-scale products plus the shifted bias.
  function automatic int acc_w(input int n_in, input int res, input int frac);
    return 2 * res + frac + $clog2(n_in + 2);
  endfunction

  function automatic int q_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int res);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (res - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (res - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mlp_sigmoid.sv
// Piecewise-linear sigmoid on a Q(RES-FRAC).FRAC word, truncated result.
// Only instantiated when MLP_SIGMOID_EN is defined.
module mlp_sigmoid
  import mlp_pkg::*;
#(
  parameter int RES  = RES_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [RES-1:0] z,
  output logic [RES-1:0] y
);

  localparam int ONE = q_one(FRAC);
  localparam int T5  = 5 * ONE;
  localparam int T2  = (19 * ONE) / 8;

  logic signed [31:0] zs;
  logic signed [31:0] a;
  logic signed [31:0] f32;
  logic signed [31:0] f;

  // Segments evaluated at 32x scale so the slopes stay exact before truncation.
  always_comb begin
    zs = 32'($signed(z));
    a  = (zs < 0) ? -zs : zs;
    if (a >= T5)       f32 = 32 * ONE;
    else if (a >= T2)  f32 = a + 27 * ONE;
    else if (a >= ONE) f32 = 4 * a + 20 * ONE;
    else               f32 = 8 * a + 16 * ONE;
    f = f32 >>> 5;
    y = RES'((zs < 0) ? (ONE - f) : f);
  end

endmodule

// File: rtl/mlp_layer_seq.sv
// Sequential fully-connected layer: one MAC swept over neurons/inputs, weights from sync-read memory.
// Build option: define MLP_SIGMOID_EN to apply the sigmoid activation (default is saturated linear).
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int N_IN  = 196,
  parameter int N_NEU = 30,
  parameter int RES   = RES_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int AW    = $clog2(N_NEU * (N_IN + 1))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 layer_go,
  input  logic [RES*N_IN-1:0]  input_data,
  output logic                 w_rd,
  output logic [AW-1:0]        w_addr,
  input  logic [RES-1:0]       w_data,
  output logic [RES*N_NEU-1:0] activations,
  output logic                 layer_busy,
  output logic                 layer_done
);

  localparam int ACC_W = acc_w(N_IN, RES, FRAC);
  localparam int IW    = $clog2(N_IN + 1);
  localparam int NW    = (N_NEU > 1) ? $clog2(N_NEU) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN);
  localparam logic [NW-1:0] N_LAST = NW'(N_NEU - 1);

  state_e                  state_q, state_d;
  logic [RES*N_IN-1:0]     x_q, x_d;
  logic [NW-1:0]           n_q, n_d;
  logic [IW-1:0]           i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_bias_q, rd_bias_d;
  logic [IW-1:0]           rd_idx_q, rd_idx_d;
  logic [RES*N_NEU-1:0]    act_q, act_d;
  logic                    w_rd_q, w_rd_d;
  logic [AW-1:0]           w_addr_q, w_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic signed [RES-1:0]   x_el;
  logic signed [RES-1:0]   w_s;
  logic signed [2*RES-1:0] prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] z_full;
  logic signed [RES-1:0]   z_sat;
  logic [RES-1:0]          act_val;

  // rd_* describe the word arriving on w_data this cycle (issued one cycle earlier).
  assign x_el   = x_q[RES*rd_idx_q +: RES];
  assign w_s    = w_data;
  assign prod   = x_el * w_s;
  assign term   = rd_bias_q ? (ACC_W'(w_s) <<< FRAC) : ACC_W'(prod);
  assign z_full = acc_q >>> FRAC;
  assign z_sat  = RES'(saturate(64'(z_full), RES));

`ifdef MLP_SIGMOID_EN
  mlp_sigmoid #(.RES(RES), .FRAC(FRAC)) u_sigmoid (.z(z_sat), .y(act_val));
`else
  assign act_val = z_sat;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    n_d       = n_q;
    i_d       = i_q;
    acc_d     = acc_q;
    rd_vld_d  = 1'b0;
    rd_bias_d = 1'b0;
    rd_idx_d  = rd_idx_q;
    act_d     = act_q;
    w_rd_d    = w_rd_q;
    w_addr_d  = w_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (rd_vld_q) acc_d = acc_q + term;

    case (state_q)
      ST_IDLE: begin
        if (layer_go) begin
          x_d      = input_data;
          n_d      = '0;
          i_d      = '0;
          acc_d    = '0;
          w_rd_d   = 1'b1;
          w_addr_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_vld_d  = 1'b1;
        rd_idx_d  = i_q;
        rd_bias_d = (i_q == I_LAST);
        if (i_q == I_LAST) begin
          w_rd_d  = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          i_d      = i_q + IW'(1);
          w_addr_d = w_addr_q + AW'(1);
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        act_d[RES*n_q +: RES] = act_val;
        acc_d = '0;
        if (n_q == N_LAST) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          // Memory layout is contiguous, so the next neuron starts right after this bias.
          n_d      = n_q + NW'(1);
          i_d      = '0;
          w_rd_d   = 1'b1;
          w_addr_d = w_addr_q + AW'(1);
          state_d  = ST_FETCH;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      acc_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_bias_q <= 1'b0;
      rd_idx_q  <= '0;
      act_q     <= '0;
      w_rd_q    <= 1'b0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      n_q       <= n_d;
      i_q       <= i_d;
      acc_q     <= acc_d;
      rd_vld_q  <= rd_vld_d;
      rd_bias_q <= rd_bias_d;
      rd_idx_q  <= rd_idx_d;
      act_q     <= act_d;
      w_rd_q    <= w_rd_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_rd        = w_rd_q;
  assign w_addr      = w_addr_q;
  assign activations = act_q;
  assign layer_busy  = busy_q;
  assign layer_done  = done_q;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Self-checking bench for mlp_layer_seq: arithmetic reference model, per-cycle compare, literal anchors.
module tb_mlp_layer_seq;

  localparam int N_IN   = 4;
  localparam int N_NEU  = 2;
  localparam int RES    = 8;
  localparam int FRAC   = 4;
  localparam int ONE    = 1 << FRAC;
  localparam int AW     = $clog2(N_NEU * (N_IN + 1));
  localparam int NWORDS = N_NEU * (N_IN + 1);
  localparam int TD     = N_NEU * (N_IN + 3) + 1;

`ifdef MLP_SIGMOID_EN
  localparam int L_Z0 = 8, L_Z32 = 14, L_ZM32 = 2, L_Z127 = 16, L_ZM128 = 0;
`else
  localparam int L_Z0 = 0, L_Z32 = 32, L_ZM32 = -32, L_Z127 = 127, L_ZM128 = -128;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 layer_go = 1'b0;
  logic [RES*N_IN-1:0]  input_data = '0;
  logic                 w_rd;
  logic [AW-1:0]        w_addr;
  logic [RES-1:0]       w_data;
  logic [RES*N_NEU-1:0] activations;
  logic                 layer_busy;
  logic                 layer_done;

  always #5 clk = ~clk;

  mlp_layer_seq #(.N_IN(N_IN), .N_NEU(N_NEU), .RES(RES), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .layer_go(layer_go), .input_data(input_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .activations(activations),
    .layer_busy(layer_busy), .layer_done(layer_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic signed [RES-1:0] mem [NWORDS];
  int addr_log[$];
  int m_cnt = 0;
  int act_exp [N_NEU];
  int pend [N_NEU];
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int act_of(input int n);
    return int'($signed(activations[RES*n +: RES]));
  endfunction

`ifdef MLP_SIGMOID_EN
  function automatic int sig_model(input int z);
    real a, f;
    int  fq;
    a = $itor((z < 0) ? -z : z) / $itor(ONE);
    if (a >= 5.0)        f = 1.0;
    else if (a >= 2.375) f = a / 32.0 + 0.84375;
    else if (a >= 1.0)   f = a / 8.0 + 0.625;
    else                 f = a / 4.0 + 0.5;
    fq = $rtoi(f * $itor(ONE));
    return (z < 0) ? ONE - fq : fq;
  endfunction
`endif

  function automatic int model_neuron(input logic [RES*N_IN-1:0] xv, input int n);
    int sum, z;
    sum = int'(mem[n*(N_IN+1) + N_IN]) * ONE;
    for (int i = 0; i < N_IN; i++)
      sum += int'($signed(xv[RES*i +: RES])) * int'(mem[n*(N_IN+1) + i]);
    z = sum >>> FRAC;
    if (z > (1 << (RES-1)) - 1) z = (1 << (RES-1)) - 1;
    if (z < -(1 << (RES-1)))    z = -(1 << (RES-1));
`ifdef MLP_SIGMOID_EN
    return sig_model(z);
`else
    return z;
`endif
  endfunction

  // Synchronous-read weight memory with an address log per run.
  always @(posedge clk) begin
    if (w_rd) w_data <= mem[w_addr];
    if (reset) addr_log.delete();
    else if (w_rd) addr_log.push_back(int'(w_addr));
  end

  // Reference timeline: m_cnt counts cycles since acceptance, TD is the done cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      for (int n = 0; n < N_NEU; n++) act_exp[n] = 0;
      started = 1'b1;
    end else if (m_cnt == 0) begin
      if (layer_go) begin
        m_cnt = 1;
        for (int n = 0; n < N_NEU; n++) pend[n] = model_neuron(input_data, n);
      end
    end else if (m_cnt == TD) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == TD) for (int n = 0; n < N_NEU; n++) act_exp[n] = pend[n];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int p;
      bit e_wrd;
      p = (m_cnt - 1) % (N_IN + 3);
      e_wrd = (m_cnt != 0) && (m_cnt < TD) && (p <= N_IN);
      chk("busy", int'(layer_busy), int'(m_cnt != 0));
      chk("done", int'(layer_done), int'(m_cnt == TD));
      chk("w_rd", int'(w_rd), int'(e_wrd));
      if (e_wrd) chk("w_addr", int'(w_addr), ((m_cnt - 1) / (N_IN + 3)) * (N_IN + 1) + p);
      if (m_cnt == 0 || m_cnt == TD)
        for (int n = 0; n < N_NEU; n++) chk("act", act_of(n), act_exp[n]);
      if (m_cnt == TD) begin
        chk("addr_count", addr_log.size(), NWORDS);
        for (int i = 0; i < addr_log.size() && i < NWORDS; i++) chk("addr_seq", addr_log[i], i);
        addr_log.delete();
      end
    end
  end

  task automatic load(input int xv, input int wv0, input int wv1, input int b0, input int b1);
    for (int i = 0; i < N_IN; i++) begin
      input_data[RES*i +: RES] = RES'(xv);
      mem[i]                   = RES'(wv0);
      mem[N_IN + 1 + i]        = RES'(wv1);
    end
    mem[N_IN]         = RES'(b0);
    mem[2 * N_IN + 1] = RES'(b1);
  endtask

  // One go pulse; returns edges from the accepting edge to the done cycle, ends at done negedge.
  task automatic do_run(output int lat);
    int c;
    lat = -1;
    @(negedge clk);
    layer_go = 1'b1;
    @(posedge clk);
    c = 1;
    @(negedge clk);
    layer_go = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (layer_done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    if (lat < 0) chk("run_timeout", 0, 1);
  endtask

  task automatic rand_run();
    bit d, seen;
    seen = 1'b0;
    @(negedge clk);
    layer_go = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      d = layer_done;
      layer_go = 1'($urandom_range(0, 1));
      for (int i = 0; i < N_IN; i++) input_data[RES*i +: RES] = RES'($urandom);
      if (d) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rand_timeout", 0, 1);
    @(negedge clk);
    layer_go = 1'b0;
  endtask

  initial begin
    int lat, dones;
    bit found;
    for (int i = 0; i < NWORDS; i++) mem[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(layer_busy), 0);
    chk("rst_done", int'(layer_done), 0);
    chk("rst_w_rd", int'(w_rd), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_act0", act_of(0), 0);
    chk("rst_act1", act_of(1), 0);
    reset = 1'b0;

    load(16, 8, 8, 0, 0);
    do_run(lat);
    chk("latency", lat, 15);
    chk("t1_act0", act_of(0), L_Z32);
    chk("t1_act1", act_of(1), L_Z32);

    load(16, 8, 8, 0, -32);
    do_run(lat);
    chk("t2_act0", act_of(0), L_Z32);
    chk("t2_act1", act_of(1), L_Z0);

    load(127, 127, -128, 0, 0);
    do_run(lat);
    chk("sat_pos", act_of(0), L_Z127);
    chk("sat_neg", act_of(1), L_ZM128);

    load(16, 0, 0, 0, 32);
    do_run(lat);
    chk("z0", act_of(0), L_Z0);
    chk("z32", act_of(1), L_Z32);
    load(16, 0, 0, -32, 127);
    do_run(lat);
    chk("zm32", act_of(0), L_ZM32);
    chk("z127", act_of(1), L_Z127);

    // Reset in the middle of neuron 1's fetch.
    load(16, 8, 8, 0, 0);
    @(negedge clk);
    layer_go = 1'b1;
    @(negedge clk);
    layer_go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (w_rd && int'(w_addr) == N_IN + 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("mid_fetch_timeout", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(layer_busy), 0);
    chk("mid_rst_done", int'(layer_done), 0);
    chk("mid_rst_w_rd", int'(w_rd), 0);
    chk("mid_rst_w_addr", int'(w_addr), 0);
    chk("mid_rst_act0", act_of(0), 0);
    chk("mid_rst_act1", act_of(1), 0);
    reset = 1'b0;
    load(16, 8, 8, 0, -32);
    do_run(lat);
    chk("post_rst_act0", act_of(0), L_Z32);
    chk("post_rst_act1", act_of(1), L_Z0);

    // go held high for 32 edges: exactly two runs fit.
    @(negedge clk);
    layer_go = 1'b1;
    dones = 0;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (layer_done) dones++;
      if (c == 32) layer_go = 1'b0;
    end
    chk("held_go_runs", dones, 2);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NWORDS; i++) mem[i] = RES'($urandom_range(0, 255));
      for (int i = 0; i < N_IN; i++) input_data[RES*i +: RES] = RES'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_run();
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mlp_layer_seq.md
# mlp_layer_seq

Parametrised, time-multiplexed fully-connected layer: one signed MAC is swept over every neuron and input, with weights and biases fetched from an external synchronous-read memory. It replaces the fully parallel hidden/output layer pair, so one instance per layer (hidden N_IN=196/N_NEU=30, output N_IN=30/N_NEU=10) fits the FPGA DSP budget. Accepts a go pulse, latches the input vector, streams the computation and returns a registered activation vector with a done pulse.

## Interface
- N_IN, 196, inputs per neuron (≥1)
- N_NEU, 30, neurons in layer (≥1)
- RES, 8, signed word width of inputs, weights, biases, activations
- FRAC, 4, fractional bits (Q(RES-FRAC).FRAC for all words)
- AW, $clog2(N_NEU*(N_IN+1)), weight-memory address width (derived)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- layer_go  in  1  start request; sampled only in IDLE
- input_data  in  RES*N_IN  signed inputs, element i at [RES*i +: RES]
- w_rd  out  1  weight-memory read strobe
- w_addr  out  AW  address; word n*(N_IN+1)+i = weight(n,i), word n*(N_IN+1)+N_IN = bias(n)
- w_data  in  RES  signed word, valid cycle after w_rd
- activations  out  RES*N_NEU  neuron n at [RES*n +: RES], registered
- layer_busy  out  1  high from cycle after accepted go until done cycle inclusive
- layer_done  out  1  one-cycle pulse, activations valid

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: layer_go=1 → latch input_data into internal register array, clear neuron counter n and input counter i, clear accumulator → FETCH.
- FETCH: w_rd=1, w_addr=n*(N_IN+1)+i; i increments each cycle to N_IN (bias), then → DRAIN. Returned data for i<N_IN: acc += x[i]*w; for i=N_IN: acc += w<<FRAC.
- DRAIN: consumes last returned word (bias), w_rd=0 → WRITE.
- WRITE: z = acc >>> FRAC (arithmetic), saturated to [-2^(RES-1), 2^(RES-1)-1]; activation function applied; stored into slot n; acc cleared; n==N_NEU-1 → DONE else n++, i=0 → FETCH.
- DONE: layer_done=1 for one cycle → IDLE. activations hold until next WRITE to each slot.
- Accumulator width ACC_W = 2*RES+FRAC+$clog2(N_IN+2); no overflow possible internally; saturation only at WRITE.
- layer_go outside IDLE (including DONE cycle) ignored; input_data changes after acceptance have no effect.
- Reset at any time: state IDLE, counters/accumulator/activations zero, layer_busy=0, layer_done=0, w_rd=0, w_addr=0. No partial results survive.

## Timing
- Per neuron: N_IN+1 FETCH + 1 DRAIN + 1 WRITE = N_IN+3 cycles.
- go sampled at edge k → layer_done high during cycle k+1+N_NEU*(N_IN+3); layer_busy high for exactly those intervening cycles.
- Memory latency fixed at one cycle; no backpressure.
- Earliest next accepted go: first IDLE cycle after layer_done.

## Configuration
- MLP_SIGMOID_EN defined: WRITE applies piecewise-linear sigmoid to z (on |z|: ≥5 →1.0; [2.375,5) →|z|/32+0.84375; [1,2.375) →|z|/8+0.625; [0,1) →|z|/4+0.5; z<0 → 1.0-f(|z|)), result in Q format, truncated.
- Undefined: activation is saturated z (linear); no sigmoid logic synthesised. Latency identical in both builds.

## Structure
- Package mlp_pkg: default RES/FRAC, state enum, ACC_W function, saturate function, Q constants (ONE=1<<FRAC).
- Sub-module mlp_sigmoid (combinational, RES/FRAC parameters), instantiated only under MLP_SIGMOID_EN.

## Test plan
- N_IN=4,N_NEU=2,RES=8,FRAC=4, no macro: inputs all 16 (1.0), weights 8 (0.5), bias 0 → both activations 32; done exactly 15 cycles after go.
- Same, bias(1)=-32 → activation1=0; activation0=32.
- Saturation: inputs 127, weights 127 → 127; weights -128 → -128.
- With MLP_SIGMOID_EN: z=0 → 8; z=32 (2.0) → 14; z=-32 → 2; z=127 → 16.
- Reset asserted mid-FETCH of neuron 1 → next cycle all outputs 0, IDLE; new go gives correct full result.
- go held high continuously and pulsed during busy/done → only IDLE-cycle go accepted; address sequence 0..9 per run, no extra runs.
